line_drawer: RTL and testbench

Pixel-writer engine that feeds the black-and-white VGA framebuffer's write port (`x`, `y`, `pixel_color`, `pixel_write`). On command it either rasterises a straight line between two endpoints with integer Bresenham, or fills the whole 640×480 screen with one colour. It emits at most one pixel write per `clk50` cycle and reports completion with a busy/done handshake. It sits between lab control logic (switches, animation FSM) and the framebuffer.

---
 rtl/line_drawer_pkg.sv | 24 ++
 rtl/raster_scan.sv | 47 ++++
 rtl/line_drawer.sv | 183 ++++++++++++++++++
 tb/tb_line_drawer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/line_drawer_pkg.sv
// Shared types and constants for the line/fill pixel writer.
// Screen geometry defaults match the 640x480 framebuffer.
package line_drawer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DRAW,
        CLEAR,
        FIN
    } state_t;

    localparam int COORD_W = 11;
    localparam int XMAX    = 640;
    localparam int YMAX    = 480;

    // Two extra bits keep 2*err and err+dx/dy in range for any endpoints.
    function automatic int err_width(input int w);
        return w + 2;
    endfunction

    localparam int ERR_W = err_width(COORD_W);

endpackage

// File: rtl/raster_scan.sv
// Wrap-around x/y raster counter, x fastest, used for full-screen fill.
// nx/ny present the successor of the current position.
module raster_scan #(
    parameter int WIDTH = 11,
    parameter int XMAX  = 640,
    parameter int YMAX  = 480
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             init,
    input  logic             en,
    output logic [WIDTH-1:0] nx,
    output logic [WIDTH-1:0] ny,
    output logic             last
);

    localparam logic [WIDTH-1:0] XL = WIDTH'(XMAX - 1);
    localparam logic [WIDTH-1:0] YL = WIDTH'(YMAX - 1);

    logic [WIDTH-1:0] xq;
    logic [WIDTH-1:0] yq;
    logic             x_end;
    logic             y_end;

    assign x_end = (xq == XL);
    assign y_end = (yq == YL);
    assign last  = x_end && y_end;

    always_comb begin
        nx = x_end ? '0 : xq + WIDTH'(1);
        ny = yq;
        if (x_end) begin
            ny = y_end ? '0 : yq + WIDTH'(1);
        end
    end

    always_ff @(posedge clk50) begin
        if (reset || init) begin
            xq <= '0;
            yq <= '0;
        end else if (en) begin
            xq <= nx;
            yq <= ny;
        end
    end

endmodule

// File: rtl/line_drawer.sv
// Pixel writer: Bresenham line or full-screen fill into the
// framebuffer write port, at most one write per clk50 cycle.
module line_drawer #(
    parameter int WIDTH = line_drawer_pkg::COORD_W,
    parameter int XMAX  = line_drawer_pkg::XMAX,
    parameter int YMAX  = line_drawer_pkg::YMAX
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             color,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             pixel_color,
    output logic             pixel_write
);

    import line_drawer_pkg::*;

    localparam int EW = err_width(WIDTH);
    localparam logic [WIDTH-1:0] XLIM = WIDTH'(XMAX);
    localparam logic [WIDTH-1:0] YLIM = WIDTH'(YMAX);

    state_t state_q, state_d;

    logic [WIDTH-1:0] x0r, y0r, x1r, y1r;
    logic [WIDTH-1:0] cx, cy, cx_n, cy_n;
    logic [WIDTH-1:0] scan_nx, scan_ny;
    logic             colr, scan_last;
    logic             xinc, yinc, at_end, step_x, step_y;
    logic             go_clear, go_line, in_init, draw_step, clear_step;
    logic signed [EW-1:0] sx0, sy0, sx1, sy1;
    logic signed [EW-1:0] dx, dy, err, e2, err_n;

    function automatic logic on_screen(input logic [WIDTH-1:0] px,
                                       input logic [WIDTH-1:0] py);
        return (px < XLIM) && (py < YLIM);
    endfunction

    assign go_clear   = (state_q == IDLE) && clear;
    assign go_line    = (state_q == IDLE) && start && !clear;
    assign in_init    = (state_q == INIT);
    assign at_end     = (cx == x1r) && (cy == y1r);
    assign draw_step  = (state_q == DRAW) && !at_end;
    assign clear_step = (state_q == CLEAR) && !scan_last;

    // Endpoints are latched, so these stay constant for the whole line.
    assign sx0  = $signed({2'b00, x0r});
    assign sy0  = $signed({2'b00, y0r});
    assign sx1  = $signed({2'b00, x1r});
    assign sy1  = $signed({2'b00, y1r});
    assign xinc = (x0r < x1r);
    assign yinc = (y0r < y1r);
    assign dx   = (sx1 > sx0) ? sx1 - sx0 : sx0 - sx1;
    assign dy   = (sy1 > sy0) ? sy0 - sy1 : sy1 - sy0;

    always_comb begin
        e2     = err + err;
        step_x = (e2 >= dy);
        step_y = (e2 <= dx);
        err_n  = err;
        cx_n   = cx;
        cy_n   = cy;
        if (step_x) begin
            err_n = err_n + dy;
            cx_n  = xinc ? cx + WIDTH'(1) : cx - WIDTH'(1);
        end
        if (step_y) begin
            err_n = err_n + dx;
            cy_n  = yinc ? cy + WIDTH'(1) : cy - WIDTH'(1);
        end
    end

    raster_scan #(
        .WIDTH (WIDTH),
        .XMAX  (XMAX),
        .YMAX  (YMAX)
    ) u_scan (
        .clk50 (clk50),
        .reset (reset),
        .init  (go_clear),
        .en    (clear_step),
        .nx    (scan_nx),
        .ny    (scan_ny),
        .last  (scan_last)
    );

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                end else if (start) begin
                    state_d = INIT;
                end
            end
            INIT:    state_d = DRAW;
            DRAW:    if (at_end) state_d = FIN;
            CLEAR:   if (scan_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FIN);
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            x0r         <= '0;
            y0r         <= '0;
            x1r         <= '0;
            y1r         <= '0;
            colr        <= 1'b0;
            cx          <= '0;
            cy          <= '0;
            err         <= '0;
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
        end else begin
            pixel_write <= 1'b0;
            unique case (1'b1)
                go_clear: begin
                    x           <= '0;
                    y           <= '0;
                    pixel_color <= color;
                    pixel_write <= 1'b1;
                end
                go_line: begin
                    x0r  <= x0;
                    y0r  <= y0;
                    x1r  <= x1;
                    y1r  <= y1;
                    colr <= color;
                end
                in_init: begin
                    err         <= dx + dy;
                    cx          <= x0r;
                    cy          <= y0r;
                    x           <= x0r;
                    y           <= y0r;
                    pixel_color <= colr;
                    pixel_write <= on_screen(x0r, y0r);
                end
                draw_step: begin
                    err         <= err_n;
                    cx          <= cx_n;
                    cy          <= cy_n;
                    x           <= cx_n;
                    y           <= cy_n;
                    pixel_write <= on_screen(cx_n, cy_n);
                end
                clear_step: begin
                    x           <= scan_nx;
                    y           <= scan_ny;
                    pixel_write <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Scoreboard bench for line_drawer on a reduced 40x30 screen.
// Expected writes are queued at command issue and popped per write.
module tb_line_drawer;

    localparam int W  = 11;
    localparam int XM = 40;
    localparam int YM = 30;
    localparam int BUDGET = XM * YM + 64;

    logic          clk50 = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic          color = 1'b0;
    logic          busy, done, pixel_color, pixel_write;
    logic [W-1:0]  x, y;

    logic [31:0]   exp_q[$];
    int            errors = 0;
    int            checks = 0;

    line_drawer #(.WIDTH(W), .XMAX(XM), .YMAX(YM)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .color       (color),
        .busy        (busy),
        .done        (done),
        .x           (x),
        .y           (y),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int px, input int py,
                                       input logic c);
        return {9'd0, W'(px), W'(py), c};
    endfunction

    task automatic push(input int px, input int py, input logic c);
        exp_q.push_back(pk(px, py, c));
    endtask

    // Reference Bresenham over plain ints, with off-screen steps dropped.
    task automatic push_line(input int ax0, input int ay0, input int ax1,
                             input int ay1, input logic c);
        int dx, dy, sx, sy, err, e2, px, py;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        px  = ax0;
        py  = ay0;
        for (int n = 0; n < 4096; n++) begin
            if (px < XM && py < YM) push(px, py, c);
            if (px == ax1 && py == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; px += sx; end
            if (e2 <= dx) begin err += dx; py += sy; end
        end
    endtask

    // Issue a command and drain it; cycle 0 is the sample after acceptance.
    task automatic run_cmd(input string tag, input logic clr,
                           input logic st, input int ax0, input int ay0,
                           input int ax1, input int ay1, input logic c,
                           input int first_exp, input int done_exp,
                           input bit hold);
        int  cyc, first;
        bit  got_done;
        @(negedge clk50);
        x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
        color = c; start = st; clear = clr;
        @(posedge clk50); #1;
        check({tag, "/busy"}, 32'(busy), 32'd1);
        clear = 1'b0;
        if (!hold) start = 1'b0;
        x0 = W'($urandom); y0 = W'($urandom);
        x1 = W'($urandom); y1 = W'($urandom);
        color = ~c;
        cyc = 0; first = -1; got_done = 0;
        while (!got_done && cyc < BUDGET) begin
            if (pixel_write) begin
                if (first < 0) first = cyc;
                if (exp_q.size() == 0)
                    check({tag, "/extra"}, 32'd1, 32'd0);
                else
                    check({tag, "/px"}, pk(x, y, pixel_color),
                          exp_q.pop_front());
            end
            if (done) begin
                got_done = 1;
                start = 1'b0;
                check({tag, "/fin_pw"}, 32'(pixel_write), 32'd0);
            end else begin
                @(posedge clk50); #1;
                cyc++;
            end
        end
        check({tag, "/done_seen"}, 32'(got_done), 32'd1);
        check({tag, "/done_cyc"}, 32'(cyc), 32'(done_exp));
        check({tag, "/first"}, 32'(first), 32'(first_exp));
        check({tag, "/missing"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk50); #1;
        check({tag, "/idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "/idle_pw"}, 32'(pixel_write), 32'd0);
    endtask

    initial begin
        int nw, cyc, stray;

        repeat (3) @(posedge clk50);
        #1;
        check("rst/ctl", {29'd0, busy, done, pixel_write}, 32'd0);
        check("rst/px", pk(x, y, pixel_color), 32'd0);
        @(negedge clk50);
        reset = 1'b0;

        for (int i = 0; i <= 5; i++) push(i, 0, 1'b1);
        run_cmd("hline", 0, 1, 0, 0, 5, 0, 1'b1, 1, 7, 0);

        for (int i = 10; i >= 6; i--) push(10, i, 1'b1);
        run_cmd("vup", 0, 1, 10, 10, 10, 6, 1'b1, 1, 6, 0);

        push(0, 0, 1'b0); push(1, 1, 1'b0); push(2, 1, 1'b0);
        push(3, 2, 1'b0); push(4, 2, 1'b0);
        run_cmd("shallow", 0, 1, 0, 0, 4, 2, 1'b0, 1, 6, 0);

        push(7, 7, 1'b1);
        run_cmd("point", 0, 1, 7, 7, 7, 7, 1'b1, 1, 2, 1);

        push_line(25, 5, 3, 12, 1'b1);
        run_cmd("oct_a", 0, 1, 25, 5, 3, 12, 1'b1, 1, 24, 0);
        push_line(2, 25, 9, 1, 1'b0);
        run_cmd("oct_b", 0, 1, 2, 25, 9, 1, 1'b0, 1, 26, 0);
        push_line(35, 2, 45, 4, 1'b1);
        run_cmd("part_clip", 0, 1, 35, 2, 45, 4, 1'b1, 1, 12, 0);

        run_cmd("clip", 0, 1, 700, 0, 702, 0, 1'b1, -1, 4, 0);

        for (int r = 0; r < YM; r++)
            for (int c = 0; c < XM; c++) push(c, r, 1'b0);
        run_cmd("clear", 1, 1, 3, 3, 9, 9, 1'b0, 0, XM * YM, 0);

        @(negedge clk50);
        x0 = 0; y0 = 0; x1 = 9; y1 = 0; color = 1'b1; start = 1'b1;
        @(posedge clk50); #1;
        start = 1'b0;
        nw = 0; cyc = 0;
        while (nw < 3 && cyc < 20) begin
            @(posedge clk50); #1;
            cyc++;
            if (pixel_write) nw++;
        end
        check("rst_mid/writes", 32'(nw), 32'd3);
        @(negedge clk50);
        reset = 1'b1;
        @(posedge clk50); #1;
        check("rst_mid/ctl", {29'd0, busy, done, pixel_write}, 32'd0);
        check("rst_mid/px", pk(x, y, pixel_color), 32'd0);
        @(negedge clk50);
        reset = 1'b0;
        stray = 0;
        repeat (20) begin
            @(posedge clk50); #1;
            if (pixel_write || done || busy) stray++;
        end
        check("rst_mid/quiet", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
